db_b3gen8: RTL
==============

// Module: db_b3gen8
// PURPOSE
//  Test-pattern source for SONET/SDH VC payload loopback benches.
//  Emits one byte per request slot: a PRBS15 payload stream, or in CEP mode a framed
//  payload whose path overhead carries a valid BIP. The B3 byte (VC3/VC4) or the V5
//  bits [7:6] (VT) hold the BIP of the previous frame.
//  Feeds the per-channel datapath toward the matching B3/PRBS checker on the receive side.
// PARAMETERS
//  PKMOD   0   1 = J1 generated internally when counter==1; 0 = J1 only from ij1
// PORTS
//  clk      in   1   clock
//  rst      in   1   reset, asynchronous, active-high
//  cfgcep   in   1   1 = framed CEP pattern with B3/V5 insertion; 0 = raw PRBS15
//  cfgvc3   in   1   1 = STS/VC mode (B3 BIP-8); 0 = VT mode (V5 BIP-2)
//  cfgb3    in   13  B3 byte position (counter value), also selects frame length
//  ireq     in   1   byte slot request; one output byte per ireq
//  ij1      in   1   external J1 marker, qualified by ireq
//  ierrins  in   1   single-shot error insertion request (pulse)
//  ovld     out  1   output byte valid
//  odat     out  8   output byte
//  oj1      out  1   output byte is J1/V5 position
// BEHAVIOUR
//  Reset values: ovld=0, odat=8'h00, oj1=0.
//  Internal state reset values: cnt=0, PRBS=15'h7FFF, sums=0, b3pre=0, err_arm=0.
//  Latency: fixed 1 cycle. Output is registered. ovld(t+1)=ireq(t); odat/oj1 hold while ireq=0.
//  Frame-length register, registered from cfgb3:
//    86->765, 88->783, 262->2349, 1045->9396, else 37584 (16 bits).
//  Counter cnt[15:0] advances only on ireq:
//    - ireq&ij1 -> cnt=2 (current byte is position 1).
//    - else cnt>=max -> 1.
//    - else cnt+1.
//  j1pos = ij1 | (cnt==1 & PKMOD==1). oj1 = registered (ireq & j1pos).
//  Payload: PRBS15 x^15+x^14+1, 8 bits per byte, MSB first. Advances only on ireq, in all modes.
//  cfgcep=0: odat=PRBS byte always; no overhead insertion; oj1 still reported.
//  cfgcep=1, cfgvc3=1 (BIP-8 over every emitted byte, J1 through the last byte before the next J1):
//    - On ireq&j1pos: b3pre<=b3sum; b3sum<=odat_next.
//    - Else on ireq: b3sum<=b3sum^odat_next.
//    - On ireq & cnt==cfgb3: odat_next=b3pre, otherwise the PRBS byte.
//  cfgcep=1, cfgvc3=0 (BIP-2):
//    - fold(x) = x[7:6]^x[5:4]^x[3:2]^x[1:0].
//    - At j1pos: odat_next[7:6]=bip2 (sum before this byte); bits[5:0] are PRBS.
//    - bip2 <= (j1pos?0:bip2) ^ fold(odat_next).
//  Sums are always computed on the byte actually emitted, including inserted overhead.
//  Error insertion: ierrins sets err_arm. The next qualifying byte is corrupted, then err_arm clears:
//    - CEP VC3: the B3 byte, odat[0] inverted.
//    - CEP VT: the V5 byte, odat[6] inverted.
//    - PRBS mode: the next ireq byte, odat[0] inverted.
//    The corrupted byte enters the sums. ierrins while armed is ignored (one error per arm).
//  Boundaries:
//    - ij1 and cnt>=max together: ij1 wins (cnt=2).
//    - cfgb3 beyond max: the B3 position is never hit; no insertion.
//    - First frame after reset inserts b3pre=0.
//    - A cfg change mid-frame takes effect at the next ireq; no flush.
//    - rst mid-frame restores all reset values immediately.
// STRUCTURE
//  Shared package: the frame-length constants (765/783/2349/9396/37584), the cfgb3 codes
//  (86/88/262/1045) and the PRBS15 seed, shared with the checker.
//  Sub-module: db_prbs15gen8 (combinational next-state plus byte for PRBS15, 8 bits per step).
//  Use the same sub-module for the checker's reference model.
//  Top level: counter, BIP accumulators, b3pre register, insertion mux, error-arm flag, output flops.
// TESTING
//  1. Reset, cfgcep=0, ireq=1 continuously:
//     -> ovld rises 1 cycle later; 1000 bytes match the PRBS15 model from seed 7FFF; checker osyn.
//  2. cfgcep=1, cfgvc3=1, cfgb3=88, ij1 every 783 ireq:
//     -> byte 88 of frame N+1 equals XOR of all 783 bytes of frame N; checker reports 0 errors.
//  3. cfgcep=1, cfgvc3=0, cfgb3=86, PKMOD=1, no ij1:
//     -> cnt wraps at 765; oj1 every 765 bytes; V5[7:6] equals the frame BIP-2.
//  4. ierrins pulse mid-frame (VC3):
//     -> exactly one B3 byte with bit0 flipped; the next frame's B3 is correct for the corrupted
//        data; checker counts exactly 1 error.
//  5. ireq gapped 1-of-3 plus an early ij1 at cnt=400:
//     -> PRBS does not advance on idle; cnt restarts at 2; b3pre latches the partial-frame sum.
//  6. rst asserted at cnt=500:
//     -> ovld/odat/oj1=0 immediately; after release, PRBS restarts from 7FFF and the first B3 is 00.

Source files
------------

// File: rtl/db_b3gen8_pkg.sv
// Shared constants for the B3/V5 pattern generator and its receive-side checker:
// frame lengths, B3 position codes and the PRBS15 seed.
package db_b3gen8_pkg;

  localparam logic [12:0] CFGB3_86   = 13'd86;
  localparam logic [12:0] CFGB3_88   = 13'd88;
  localparam logic [12:0] CFGB3_262  = 13'd262;
  localparam logic [12:0] CFGB3_1045 = 13'd1045;

  localparam logic [15:0] FLEN_765   = 16'd765;
  localparam logic [15:0] FLEN_783   = 16'd783;
  localparam logic [15:0] FLEN_2349  = 16'd2349;
  localparam logic [15:0] FLEN_9396  = 16'd9396;
  localparam logic [15:0] FLEN_37584 = 16'd37584;

  localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

  // The B3 position code doubles as the frame-size selector.
  function automatic logic [15:0] frame_len(input logic [12:0] b3pos);
    logic [15:0] len;
    case (b3pos)
      CFGB3_86:   len = FLEN_765;
      CFGB3_88:   len = FLEN_783;
      CFGB3_262:  len = FLEN_2349;
      CFGB3_1045: len = FLEN_9396;
      default:    len = FLEN_37584;
    endcase
    return len;
  endfunction

  function automatic logic [1:0] fold2(input logic [7:0] x);
    return x[7:6] ^ x[5:4] ^ x[3:2] ^ x[1:0];
  endfunction

endpackage

// File: rtl/db_prbs15gen8.sv
// PRBS15 (x^15 + x^14 + 1) stepper: eight serial shifts per call, first bit lands in the MSB.
module db_prbs15gen8
  import db_b3gen8_pkg::*;
(
  input  logic [14:0] state_i,
  output logic [14:0] state_o,
  output logic [7:0]  byte_o
);

  logic [14:0] s;
  logic        fb;

  always_comb begin
    s      = state_i;
    fb     = 1'b0;
    byte_o = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb             = s[14] ^ s[13];
      s              = {s[13:0], fb};
      byte_o[7 - i]  = fb;
    end
    state_o = s;
  end

endmodule

// File: rtl/db_b3gen8.sv
// Loopback pattern source: PRBS15 payload, optionally framed with B3 (BIP-8) or
// V5 (BIP-2) overhead carrying the previous frame's parity, plus one-shot error insertion.
module db_b3gen8
  import db_b3gen8_pkg::*;
#(
  parameter bit PKMOD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfgcep,
  input  logic        cfgvc3,
  input  logic [12:0] cfgb3,
  input  logic        ireq,
  input  logic        ij1,
  input  logic        ierrins,
  output logic        ovld,
  output logic [7:0]  odat,
  output logic        oj1
);

  logic [15:0] max_q, max_d;
  logic [15:0] cnt_q, cnt_d;
  logic [14:0] prbs_q, prbs_d, prbs_nxt;
  logic [7:0]  prbs_byte;
  logic [7:0]  b3sum_q, b3sum_d;
  logic [7:0]  b3pre_q, b3pre_d;
  logic [1:0]  bip2_q, bip2_d;
  logic        err_arm_q, err_arm_d;
  logic        ovld_q, ovld_d;
  logic [7:0]  odat_q, odat_d;
  logic        oj1_q, oj1_d;

  logic        j1pos;
  logic        b3hit;
  logic        err_qual;
  logic [7:0]  byte_sel;

  db_prbs15gen8 u_prbs (
    .state_i (prbs_q),
    .state_o (prbs_nxt),
    .byte_o  (prbs_byte)
  );

  always_comb begin
    max_d     = frame_len(cfgb3);
    cnt_d     = cnt_q;
    prbs_d    = prbs_q;
    b3sum_d   = b3sum_q;
    b3pre_d   = b3pre_q;
    bip2_d    = bip2_q;
    err_arm_d = err_arm_q;
    ovld_d    = ireq;
    odat_d    = odat_q;
    oj1_d     = oj1_q;

    j1pos = ij1 | ((cnt_q == 16'd1) & PKMOD);
    b3hit = (cnt_q == {3'b000, cfgb3});

    // Which byte an armed error lands on depends on the active pattern mode.
    if (cfgcep) err_qual = cfgvc3 ? b3hit : j1pos;
    else        err_qual = 1'b1;

    byte_sel = prbs_byte;
    if (cfgcep && cfgvc3 && b3hit) begin
      byte_sel = b3pre_q;
    end else if (cfgcep && !cfgvc3 && j1pos) begin
      byte_sel[7:6] = bip2_q;
    end
    if (err_arm_q && err_qual) begin
      if (cfgcep && !cfgvc3) byte_sel[6] = ~byte_sel[6];
      else                   byte_sel[0] = ~byte_sel[0];
    end

    if (ireq) begin
      prbs_d = prbs_nxt;
      if (ij1)                cnt_d = 16'd2;
      else if (cnt_q >= max_q) cnt_d = 16'd1;
      else                    cnt_d = cnt_q + 16'd1;

      // Parity always covers the byte actually emitted, overhead and errors included.
      if (j1pos) begin
        b3pre_d = b3sum_q;
        b3sum_d = byte_sel;
      end else begin
        b3sum_d = b3sum_q ^ byte_sel;
      end
      bip2_d = (j1pos ? 2'b00 : bip2_q) ^ fold2(byte_sel);

      odat_d = byte_sel;
      oj1_d  = j1pos;
    end

    if (err_arm_q) err_arm_d = ~(ireq & err_qual);
    else           err_arm_d = ierrins;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q     <= FLEN_37584;
      cnt_q     <= 16'd0;
      prbs_q    <= PRBS15_SEED;
      b3sum_q   <= 8'h00;
      b3pre_q   <= 8'h00;
      bip2_q    <= 2'b00;
      err_arm_q <= 1'b0;
      ovld_q    <= 1'b0;
      odat_q    <= 8'h00;
      oj1_q     <= 1'b0;
    end else begin
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      prbs_q    <= prbs_d;
      b3sum_q   <= b3sum_d;
      b3pre_q   <= b3pre_d;
      bip2_q    <= bip2_d;
      err_arm_q <= err_arm_d;
      ovld_q    <= ovld_d;
      odat_q    <= odat_d;
      oj1_q     <= oj1_d;
    end
  end

  assign ovld = ovld_q;
  assign odat = odat_q;
  assign oj1  = oj1_q;

endmodule
